id_ex_latch: RTL and testbench
==============================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL have en  in  1  pipeline advance (instruction fetch hit and no data-memory wait).
REQ-004 SHALL have flush  in  1  squash the ID-stage instruction (branch/jump resolved taken).
REQ-005 SHALL have id_rsel1, id_rsel2, id_wsel  in  5 each  source and destination register numbers from decode.
REQ-006 SHALL have id_rdat1, id_rdat2, id_imm, id_npc  in  32 each  register-file read data, extended immediate, PC+4.
REQ-007 SHALL have id_wen, id_dren, id_dwen, id_memtoreg, id_halt  in  1 each; id_aluop  in  4.
REQ-008 SHALL have ex_* outputs matching every id_* input field (same widths), plus ex_valid  out  1.
REQ-009 SHALL have stall  out  1  hold PC and IF/ID register this cycle.
REQ-010 SHALL have bubble_cnt  out  16  count of load-use bubbles inserted.

Function
REQ-011 SHALL define a bubble as all ex_* fields and ex_valid equal to 0.
REQ-012 SHALL, on a rising CLK edge, apply exactly one action by priority: flush > halt-hold > en low > load-use bubble > load.
REQ-013 SHALL, on flush=1, load a bubble regardless of en, and clear halt-hold.
REQ-014 SHALL, once ex_halt=1 and ex_valid=1 are registered, hold all ex_* outputs until RST or flush (halt-hold).
REQ-015 SHALL, with en=0, hold all ex_* outputs unchanged; stall and bubble_cnt are not advanced.
REQ-016 SHALL, with en=1 and stall=1, load a bubble and increment bubble_cnt by 1.
REQ-017 SHALL, with en=1 and stall=0, load every id_* field into its ex_* counterpart and set ex_valid=1, latency one cycle.
REQ-018 SHALL compute stall combinationally: ex_valid & ex_dren & (ex_wsel != 0) & ((ex_wsel == id_rsel1) | (ex_wsel == id_rsel2)).
REQ-019 SHALL drive stall=0 whenever flush=1 or halt-hold is active.
REQ-020 SHALL assert stall for at most one consecutive en=1 cycle per load, since the bubble clears ex_dren.
REQ-021 SHALL saturate bubble_cnt at 16'hFFFF, with no wrap to 0.
REQ-022 SHALL load id_wsel unmodified; the register-0 write filter belongs to downstream forwarding and writeback.

Reset
REQ-023 SHALL, while RST=1, immediately force all ex_* outputs, ex_valid, halt-hold and bubble_cnt to 0.
REQ-024 SHALL drive stall=0 during reset, as a consequence of ex_valid=0.
REQ-025 SHALL discard any in-flight bubble or load on RST assertion mid-operation.
REQ-026 SHALL resume normal loads on the first rising edge after RST deasserts.

Configuration
REQ-027 SHALL honour macro ID_EX_LOAD_USE_STALL_EN.
REQ-028 SHALL, with ID_EX_LOAD_USE_STALL_EN defined, implement REQ-016, REQ-018 to REQ-021 as written.
REQ-029 SHALL, without ID_EX_LOAD_USE_STALL_EN, tie stall=0 and bubble_cnt=0; the load-use bubble priority level is then never taken.

Verification
REQ-030 SHALL cover plain load: RST pulse, then en=1, id_wsel=5, id_rdat1=32'h1234, id_wen=1 -> next edge ex_wsel=5, ex_rdat1=32'h1234, ex_wen=1, ex_valid=1.
REQ-031 SHALL cover load-use (macro on): ex holds dren=1, wsel=8; id_rsel2=8, en=1 -> stall=1; next edge bubble, bubble_cnt=1, stall=0; following edge loads the ID instruction.
REQ-032 SHALL cover register 0: ex holds dren=1, wsel=0; id_rsel1=0 -> stall=0, no bubble.
REQ-033 SHALL cover flush priority: stall=1 and en=0 and flush=1 -> next edge bubble, bubble_cnt unchanged.
REQ-034 SHALL cover halt: load id_halt=1, then 3 edges with en=1 and new id_* values -> ex_* unchanged; assert RST mid-cycle -> outputs 0 before next edge.
REQ-035 SHALL cover saturation: preload 16'hFFFE, force 3 load-use bubbles -> bubble_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/id_ex_latch.sv
// -----------------------------------------------------------------------------
// id_ex_latch -- ID/EX pipeline register with load-use hazard detection.
//
// Purpose:
//   Captures the decoded instruction fields from the ID stage into the EX
//   stage. On each rising CLK edge exactly one action is taken, in priority
//   order: flush (squash to a bubble), halt-hold (a registered, valid halt
//   freezes the stage), hold (en low), load-use bubble, or a normal load.
//
// Ports:
//   CLK, RST           clock (rising edge); asynchronous active-high reset
//   en                 pipeline advance
//   flush              squash the ID instruction (taken branch/jump)
//   id_*               decoded fields: rsel1/rsel2/wsel[5], rdat1/rdat2/
//                      imm/npc[32], wen/dren/dwen/memtoreg/halt[1], aluop[4]
//   ex_*               registered copies of every id_* field
//   ex_valid           EX holds a real instruction (0 = bubble)
//   stall              hold PC and IF/ID this cycle (load-use hazard)
//   bubble_cnt         saturating count of load-use bubbles inserted
//
// Configuration:
//   ID_EX_LOAD_USE_STALL_EN  when defined, load-use detection, bubble
//                            insertion and bubble_cnt are built; otherwise
//                            stall and bubble_cnt are tied to 0.
// -----------------------------------------------------------------------------
module id_ex_latch (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        flush,
  input  logic [4:0]  id_rsel1,
  input  logic [4:0]  id_rsel2,
  input  logic [4:0]  id_wsel,
  input  logic [31:0] id_rdat1,
  input  logic [31:0] id_rdat2,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_npc,
  input  logic        id_wen,
  input  logic        id_dren,
  input  logic        id_dwen,
  input  logic        id_memtoreg,
  input  logic        id_halt,
  input  logic [3:0]  id_aluop,
  output logic [4:0]  ex_rsel1,
  output logic [4:0]  ex_rsel2,
  output logic [4:0]  ex_wsel,
  output logic [31:0] ex_rdat1,
  output logic [31:0] ex_rdat2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_npc,
  output logic        ex_wen,
  output logic        ex_dren,
  output logic        ex_dwen,
  output logic        ex_memtoreg,
  output logic        ex_halt,
  output logic [3:0]  ex_aluop,
  output logic        ex_valid,
  output logic        stall,
  output logic [15:0] bubble_cnt
);

  typedef struct packed {
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic [4:0]  wsel;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [31:0] npc;
    logic        wen;
    logic        dren;
    logic        dwen;
    logic        memtoreg;
    logic        halt;
    logic [3:0]  aluop;
  } ex_fields_t;

  ex_fields_t id_fields;
  ex_fields_t ex_d, ex_q;
  logic       valid_d, valid_q;
  logic       halt_hold;

  assign id_fields = '{rsel1: id_rsel1, rsel2: id_rsel2, wsel: id_wsel,
                       rdat1: id_rdat1, rdat2: id_rdat2, imm: id_imm,
                       npc: id_npc, wen: id_wen, dren: id_dren,
                       dwen: id_dwen, memtoreg: id_memtoreg, halt: id_halt,
                       aluop: id_aluop};

  // A valid halt sitting in EX freezes the stage. Deriving this from the
  // registered fields means a flush (which loads a bubble) or a reset
  // releases it without a separate flop.
  assign halt_hold = valid_q & ex_q.halt;

`ifdef ID_EX_LOAD_USE_STALL_EN
  logic        load_use;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;

  // A load in EX writing a register the ID instruction reads. Register 0
  // never carries a real dependency.
  assign load_use = valid_q & ex_q.dren & (ex_q.wsel != 5'd0) &
                    ((ex_q.wsel == id_rsel1) | (ex_q.wsel == id_rsel2));

  // Flush and halt-hold outrank the bubble, so the stall is suppressed
  // whenever either of them will decide this edge.
  assign stall = load_use & ~flush & ~halt_hold;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (en && stall && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      bubble_cnt_q <= 16'd0;
    else
      bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall      = 1'b0;
  assign bubble_cnt = 16'd0;
`endif

  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    if (flush) begin
      ex_d    = '0;
      valid_d = 1'b0;
    end else if (halt_hold || !en) begin
      // hold everything
    end else if (stall) begin
      ex_d    = '0;
      valid_d = 1'b0;
    end else begin
      ex_d    = id_fields;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
    end
  end

  assign ex_rsel1    = ex_q.rsel1;
  assign ex_rsel2    = ex_q.rsel2;
  assign ex_wsel     = ex_q.wsel;
  assign ex_rdat1    = ex_q.rdat1;
  assign ex_rdat2    = ex_q.rdat2;
  assign ex_imm      = ex_q.imm;
  assign ex_npc      = ex_q.npc;
  assign ex_wen      = ex_q.wen;
  assign ex_dren     = ex_q.dren;
  assign ex_dwen     = ex_q.dwen;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_halt     = ex_q.halt;
  assign ex_aluop    = ex_q.aluop;
  assign ex_valid    = valid_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// -----------------------------------------------------------------------------
// tb_id_ex_latch -- self-checking bench for id_ex_latch.
// Directed vector table, hand-written multi-cycle sequences, then randomized
// traffic compared against a rule-level reference model. Expectations follow
// whether ID_EX_LOAD_USE_STALL_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_id_ex_latch;

`ifdef ID_EX_LOAD_USE_STALL_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        en, flush;
  logic [4:0]  id_rsel1, id_rsel2, id_wsel;
  logic [31:0] id_rdat1, id_rdat2, id_imm, id_npc;
  logic        id_wen, id_dren, id_dwen, id_memtoreg, id_halt;
  logic [3:0]  id_aluop;
  logic [4:0]  ex_rsel1, ex_rsel2, ex_wsel;
  logic [31:0] ex_rdat1, ex_rdat2, ex_imm, ex_npc;
  logic        ex_wen, ex_dren, ex_dwen, ex_memtoreg, ex_halt;
  logic [3:0]  ex_aluop;
  logic        ex_valid, stall;
  logic [15:0] bubble_cnt;

  id_ex_latch dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_wsel(id_wsel),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_npc(id_npc),
    .id_wen(id_wen), .id_dren(id_dren), .id_dwen(id_dwen),
    .id_memtoreg(id_memtoreg), .id_halt(id_halt), .id_aluop(id_aluop),
    .ex_rsel1(ex_rsel1), .ex_rsel2(ex_rsel2), .ex_wsel(ex_wsel),
    .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_npc(ex_npc),
    .ex_wen(ex_wen), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
    .ex_memtoreg(ex_memtoreg), .ex_halt(ex_halt), .ex_aluop(ex_aluop),
    .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  rsel1, rsel2, wsel;
    logic [31:0] rdat1, rdat2, imm, npc;
    logic        wen, dren, dwen, memtoreg, halt;
    logic [3:0]  aluop;
  } fld_t;

  typedef struct {
    logic        fl, e;
    logic [4:0]  rs1, rs2, ws;
    logic        dr, h;
    logic [31:0] rd1;
    logic        exp_stall;
    logic        exp_valid;
    logic [4:0]  exp_ws;
    logic [31:0] exp_rd1;
    logic [15:0] exp_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  fld_t        m_ex;
  logic        m_valid;
  logic [15:0] m_cnt;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic fl, input logic e, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] w,
                       input logic dr, input logic h, input logic [31:0] d1);
    flush = fl; en = e;
    id_rsel1 = r1; id_rsel2 = r2; id_wsel = w;
    id_rdat1 = d1; id_rdat2 = ~d1; id_imm = d1 + 32'd1; id_npc = d1 + 32'd4;
    id_wen = 1'b1; id_dren = dr; id_dwen = 1'b0; id_memtoreg = dr;
    id_halt = h; id_aluop = d1[3:0];
  endtask

  task automatic drive_rand;
    flush = ($urandom_range(0, 11) == 0);
    en    = ($urandom_range(0, 3) != 0);
    id_rsel1 = 5'($urandom_range(0, 3));
    id_rsel2 = 5'($urandom_range(0, 3));
    id_wsel  = 5'($urandom_range(0, 3));
    id_rdat1 = $urandom; id_rdat2 = $urandom; id_imm = $urandom; id_npc = $urandom;
    id_wen = 1'($urandom); id_dren = ($urandom_range(0, 4) < 2);
    id_dwen = 1'($urandom); id_memtoreg = 1'($urandom);
    id_halt = ($urandom_range(0, 15) == 0);
    id_aluop = 4'($urandom);
  endtask

  function automatic fld_t dut_ex();
    return {ex_rsel1, ex_rsel2, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_npc,
            ex_wen, ex_dren, ex_dwen, ex_memtoreg, ex_halt, ex_aluop};
  endfunction

  function automatic fld_t cur_id();
    return {id_rsel1, id_rsel2, id_wsel, id_rdat1, id_rdat2, id_imm, id_npc,
            id_wen, id_dren, id_dwen, id_memtoreg, id_halt, id_aluop};
  endfunction

  // Stall from the rules: a valid load in EX whose nonzero destination is
  // read by the ID instruction, unless a flush or a frozen halt decides.
  function automatic logic model_stall();
    logic frozen;
    frozen = m_valid && m_ex.halt;
    return LU && !flush && !frozen && m_valid && m_ex.dren && (m_ex.wsel != 5'd0) &&
           ((m_ex.wsel == id_rsel1) || (m_ex.wsel == id_rsel2));
  endfunction

  task automatic model_edge;
    logic st;
    st = model_stall();
    if (flush) begin
      m_ex = '0; m_valid = 1'b0;
    end else if (m_valid && m_ex.halt) begin
      // frozen on halt
    end else if (!en) begin
      // held
    end else if (st) begin
      m_ex = '0; m_valid = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_ex = cur_id(); m_valid = 1'b1;
    end
  endtask

  task automatic rst_pulse;
    RST = 1'b1;
    tick;
    RST = 1'b0;
  endtask

  function automatic vec_t mkv(input logic fl, input logic e, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] w,
                               input logic dr, input logic h, input logic [31:0] d1,
                               input logic xs, input logic xv, input logic [4:0] xw,
                               input logic [31:0] xd, input logic [15:0] xc);
    vec_t v;
    v.fl = fl; v.e = e; v.rs1 = r1; v.rs2 = r2; v.ws = w; v.dr = dr; v.h = h; v.rd1 = d1;
    v.exp_stall = xs; v.exp_valid = xv; v.exp_ws = xw; v.exp_rd1 = xd; v.exp_cnt = xc;
    return v;
  endfunction

  vec_t vt[12];

  initial begin
    logic [15:0] lu16;
    logic [15:0] cnt_before;
    lu16 = {15'd0, LU};

    // fl en rs1 rs2 ws dr h rd1 | stall valid ws rd1 cnt
    vt[0]  = mkv(0,1, 1, 2, 8,1,0,32'h100,  0,1,     8, 32'h100, 16'd0);
    vt[1]  = mkv(0,1, 3, 8, 9,0,0,32'h200, LU,!LU, LU ? 5'd0 : 5'd9, LU ? 32'h0 : 32'h200, lu16);
    vt[2]  = mkv(0,1, 3, 8, 9,0,0,32'h200,  0,1,     9, 32'h200, lu16);
    vt[3]  = mkv(0,0, 9, 9,10,1,0,32'h300,  0,1,     9, 32'h200, lu16);
    vt[4]  = mkv(0,1, 0, 4, 0,1,0,32'h400,  0,1,     0, 32'h400, lu16);
    vt[5]  = mkv(0,1, 0, 0,11,0,0,32'h500,  0,1,    11, 32'h500, lu16);
    vt[6]  = mkv(0,1, 5, 6,12,1,0,32'h600,  0,1,    12, 32'h600, lu16);
    vt[7]  = mkv(1,0,12,12,13,0,0,32'h700,  0,0,     0, 32'h0,   lu16);
    vt[8]  = mkv(0,1, 1, 2,14,0,1,32'h800,  0,1,    14, 32'h800, lu16);
    vt[9]  = mkv(0,1, 1, 2,15,0,0,32'h900,  0,1,    14, 32'h800, lu16);
    vt[10] = mkv(1,1, 1, 2,15,0,0,32'h900,  0,0,     0, 32'h0,   lu16);
    vt[11] = mkv(0,1, 1, 2,16,0,0,32'hA00,  0,1,    16, 32'hA00, lu16);

    // ---------------- reset state ----------------
    RST = 1'b1;
    drive(0, 1, 1, 2, 5, 0, 0, 32'hDEAD);
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_fields", dut_ex(), 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", bubble_cnt, 0);
    tick;
    chk("rst_hold_edge", ex_valid, 0);
    RST = 1'b0;

    // ---------------- plain load ----------------
    drive(0, 1, 0, 0, 5, 0, 0, 32'h1234);
    tick;
    chk("plain_wsel", ex_wsel, 5);
    chk("plain_rdat1", ex_rdat1, 32'h1234);
    chk("plain_wen", ex_wen, 1);
    chk("plain_valid", ex_valid, 1);
    chk("plain_npc", ex_npc, 32'h1238);

    // ---------------- vector table ----------------
    rst_pulse;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].fl, vt[i].e, vt[i].rs1, vt[i].rs2, vt[i].ws, vt[i].dr, vt[i].h, vt[i].rd1);
      #1;
      chk($sformatf("vec%0d_stall", i), stall, vt[i].exp_stall);
      tick;
      chk($sformatf("vec%0d_valid", i), ex_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d_wsel", i), ex_wsel, vt[i].exp_ws);
      chk($sformatf("vec%0d_rdat1", i), ex_rdat1, vt[i].exp_rd1);
      chk($sformatf("vec%0d_cnt", i), bubble_cnt, vt[i].exp_cnt);
    end

    // ---------------- load-use sequence ----------------
    rst_pulse;
    drive(0, 1, 1, 2, 8, 1, 0, 32'h31);
    tick;
    drive(0, 1, 3, 8, 20, 0, 0, 32'h32);
    #1;
    chk("lu_stall", stall, LU);
    tick;
    chk("lu_bubble_valid", ex_valid, !LU);
    chk("lu_bubble_wsel", ex_wsel, LU ? 5'd0 : 5'd20);
    chk("lu_cnt", bubble_cnt, lu16);
    chk("lu_stall_after", stall, 0);
    tick;
    chk("lu_load_wsel", ex_wsel, 20);
    chk("lu_load_rdat1", ex_rdat1, 32'h32);
    chk("lu_load_valid", ex_valid, 1);

    // ---------------- flush priority over stall and en=0 ----------------
    drive(0, 1, 1, 2, 8, 1, 0, 32'h41);
    tick;
    cnt_before = bubble_cnt;
    drive(0, 0, 1, 8, 3, 0, 0, 32'h42);
    #1;
    chk("fl_stall_pre", stall, LU);
    flush = 1'b1;
    #1;
    chk("fl_stall_gated", stall, 0);
    tick;
    chk("fl_valid", ex_valid, 0);
    chk("fl_fields", dut_ex(), 0);
    chk("fl_cnt", bubble_cnt, cnt_before);

    // ---------------- halt hold, then reset mid-cycle ----------------
    drive(0, 1, 1, 2, 8, 1, 1, 32'h51);
    tick;
    chk("halt_loaded", ex_halt, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 8, 8, 5'(21 + k), 0, 0, 32'h60 + k);
      #1;
      chk($sformatf("halt%0d_stall", k), stall, 0);
      tick;
      chk($sformatf("halt%0d_rdat1", k), ex_rdat1, 32'h51);
      chk($sformatf("halt%0d_wsel", k), ex_wsel, 8);
      chk($sformatf("halt%0d_valid", k), ex_valid, 1);
    end
    #2;
    RST = 1'b1;
    #1;
    chk("halt_rst_valid", ex_valid, 0);
    chk("halt_rst_fields", dut_ex(), 0);
    chk("halt_rst_cnt", bubble_cnt, 0);
    tick;
    RST = 1'b0;
    drive(0, 1, 0, 0, 3, 0, 0, 32'h77);
    tick;
    chk("resume_wsel", ex_wsel, 3);
    chk("resume_valid", ex_valid, 1);

`ifdef ID_EX_LOAD_USE_STALL_EN
    // ---------------- counter saturation ----------------
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    dut.bubble_cnt_q = 16'hFFFE;
    #1;
    chk("sat_preload", bubble_cnt, 16'hFFFE);
    tick;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 2, 8, 1, 0, 32'h90 + k);
      tick;
      drive(0, 1, 8, 2, 1, 0, 0, 32'hA0 + k);
      tick;
      chk($sformatf("sat%0d_cnt", k), bubble_cnt, 16'hFFFF);
    end
`endif

    // ---------------- randomized vs model ----------------
    rst_pulse;
    m_ex = '0; m_valid = 1'b0; m_cnt = 16'd0;
    for (int i = 0; i < 400; i++) begin
      drive_rand;
      #1;
      chk($sformatf("rnd%0d_stall", i), stall, model_stall());
      model_edge;
      tick;
      chk($sformatf("rnd%0d_fields", i), dut_ex(), m_ex);
      chk($sformatf("rnd%0d_valid", i), ex_valid, m_valid);
      chk($sformatf("rnd%0d_cnt", i), bubble_cnt, m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
